// File: rtl/capture_pkg.sv
// Shared definitions for the multi-channel capture buffer.
//   STATE_W : width of the externally visible state code
//   state_e : capture/readout state encoding (also driven on the STATE port)
package capture_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle   = 3'd0,
        StArmed  = 3'd1,
        StPost   = 3'd2,
        StFrozen = 3'd3,
        StRead   = 3'd4
    } state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample memory: one write port, one registered read port, single clock.
//   clk     : clock
//   rst     : synchronous reset of the read data register only (contents are kept)
//   we      : write enable;  wr_addr / wr_data : write address and data
//   re      : read enable;   rd_addr : read address
//   rd_data : registered read data, updated one cycle after re, held otherwise
module capture_ram #(
    parameter int unsigned W  = 64,
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam int unsigned Depth = 2 ** AW;

    logic [W-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the output stage, so it only moves when a read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/multich_capture_buffer.sv
// Multi-channel circular capture buffer with trigger and post-trigger length.
//   CLK, RST          : clock, synchronous active-high reset
//   DIN, DIN_VALID    : NCH packed samples (channel k at [k*DW +: DW]) and their strobe
//   ARM, TRIG         : start circular capture, trigger event (one-cycle pulses)
//   POST_LEN          : samples written after the trigger sample, latched at ARM
//   RD_START          : start chronological readout of a frozen capture
//   DOUT, DOUT_VALID, DOUT_READY : readout stream with valid/ready handshake
//   STATE, TRIG_ADR, WRAPPED     : state code, trigger sample address, buffer-filled flag
module multich_capture_buffer
    import capture_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 9
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NCH*DW-1:0]  DIN,
    input  logic               DIN_VALID,
    input  logic               ARM,
    input  logic               TRIG,
    input  logic [AW-1:0]      POST_LEN,
    input  logic               RD_START,
    output logic [NCH*DW-1:0]  DOUT,
    output logic               DOUT_VALID,
    input  logic               DOUT_READY,
    output logic [STATE_W-1:0] STATE,
    output logic [AW-1:0]      TRIG_ADR,
    output logic               WRAPPED
);

    localparam int unsigned W = NCH * DW;
    localparam logic [AW:0] DepthCnt = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] OneCnt   = {{AW{1'b0}}, 1'b1};

    state_e        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic          wrapped_q;
    logic [AW-1:0] trig_adr_q;
    logic [AW-1:0] post_len_q;
    logic [AW-1:0] post_cnt_q;
    logic          trig_written_q;
    logic [AW-1:0] rd_addr_q;
    logic [AW:0]   issue_left_q;
    logic [AW:0]   xfer_left_q;
    logic          dout_valid_q;

    logic          wr_en;
    logic          rd_en;
    logic          xfer;
    logic          post_done;
    logic [AW:0]   read_len;

    always_comb begin
        wr_en     = ((state_q == StArmed) || (state_q == StPost)) && DIN_VALID;
        xfer      = dout_valid_q && DOUT_READY;
        // Issue a read whenever the output stage is empty or being drained this cycle.
        rd_en     = (state_q == StRead) && (issue_left_q != '0) && (!dout_valid_q || DOUT_READY);
        // If the trigger cycle had no sample, the first write in POST is the trigger sample.
        post_done = trig_written_q ? ((post_cnt_q + AW'(1)) == post_len_q)
                                   : (post_len_q == '0);
        read_len  = wrapped_q ? DepthCnt : {1'b0, wr_ptr_q};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            wrapped_q      <= 1'b0;
            trig_adr_q     <= '0;
            post_len_q     <= '0;
            post_cnt_q     <= '0;
            trig_written_q <= 1'b0;
            rd_addr_q      <= '0;
            issue_left_q   <= '0;
            xfer_left_q    <= '0;
            dout_valid_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (wr_ptr_q == {AW{1'b1}}) begin
                    wrapped_q <= 1'b1;
                end
            end

            if (rd_en) begin
                rd_addr_q    <= rd_addr_q + AW'(1);
                issue_left_q <= issue_left_q - OneCnt;
            end
            if (rd_en) begin
                dout_valid_q <= 1'b1;
            end else if (xfer) begin
                dout_valid_q <= 1'b0;
            end
            if (xfer) begin
                xfer_left_q <= xfer_left_q - OneCnt;
            end

            unique case (state_q)
                StIdle: begin
                    if (ARM) begin
                        wr_ptr_q   <= '0;
                        wrapped_q  <= 1'b0;
                        post_len_q <= POST_LEN;
                        state_q    <= StArmed;
                    end
                end
                StArmed: begin
                    if (TRIG) begin
                        trig_adr_q     <= wr_ptr_q;
                        trig_written_q <= DIN_VALID;
                        post_cnt_q     <= '0;
                        state_q        <= (DIN_VALID && (post_len_q == '0)) ? StFrozen : StPost;
                    end
                end
                StPost: begin
                    if (DIN_VALID) begin
                        if (post_done) begin
                            state_q <= StFrozen;
                        end
                        if (trig_written_q) begin
                            post_cnt_q <= post_cnt_q + AW'(1);
                        end
                        trig_written_q <= 1'b1;
                    end
                end
                StFrozen: begin
                    // Readout wins if RD_START and ARM arrive together.
                    if (RD_START) begin
                        rd_addr_q    <= wrapped_q ? wr_ptr_q : '0;
                        issue_left_q <= read_len;
                        xfer_left_q  <= read_len;
                        state_q      <= (read_len == '0) ? StIdle : StRead;
                    end else if (ARM) begin
                        wr_ptr_q   <= '0;
                        wrapped_q  <= 1'b0;
                        post_len_q <= POST_LEN;
                        state_q    <= StArmed;
                    end
                end
                StRead: begin
                    if (xfer && (xfer_left_q == OneCnt)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    capture_ram #(
        .W  (W),
        .AW (AW)
    ) u_ram (
        .clk     (CLK),
        .rst     (RST),
        .we      (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (DIN),
        .re      (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (DOUT)
    );

    assign DOUT_VALID = dout_valid_q;
    assign STATE      = state_q;
    assign TRIG_ADR   = trig_adr_q;
    assign WRAPPED    = wrapped_q;

endmodule

// File: tb/tb_multich_capture_buffer.sv
// Self-checking bench for multich_capture_buffer (AW=4, NCH=4, DW=16).
// The reference model keeps the chronological list of samples accepted since ARM;
// a readout is expected to deliver the newest min(count, DEPTH) of them in order.
module tb_multich_capture_buffer;

    localparam int unsigned NCH   = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned W     = NCH * DW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  DIN = '0;
    logic          DIN_VALID = 1'b0;
    logic          ARM = 1'b0;
    logic          TRIG = 1'b0;
    logic [AW-1:0] POST_LEN = '0;
    logic          RD_START = 1'b0;
    logic [W-1:0]  DOUT;
    logic          DOUT_VALID;
    logic          DOUT_READY = 1'b0;
    logic [2:0]    STATE;
    logic [AW-1:0] TRIG_ADR;
    logic          WRAPPED;

    multich_capture_buffer #(
        .NCH (NCH),
        .DW  (DW),
        .AW  (AW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .ARM        (ARM),
        .TRIG       (TRIG),
        .POST_LEN   (POST_LEN),
        .RD_START   (RD_START),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .STATE      (STATE),
        .TRIG_ADR   (TRIG_ADR),
        .WRAPPED    (WRAPPED)
    );

    always #5 CLK = ~CLK;

    typedef enum int {MIdle, MCap, MFrozen, MRead} mphase_e;

    mphase_e      m_phase = MIdle;
    logic [W-1:0] hist[$];
    logic [W-1:0] sb[$];
    int           m_trig = -1;
    int           m_post = 0;
    int           m_trig_adr = 0;
    logic [11:0]  cnt = '0;
    int           errors = 0;
    int           checks = 0;
    int           popped = 0;
    bit           stall_prev = 1'b0;
    logic [W-1:0] prev_dout = '0;

    function automatic logic [W-1:0] make_din(input logic [11:0] c);
        logic [W-1:0] d;
        for (int k = 0; k < NCH; k++) d[k*DW +: DW] = {4'(k), c};
        return d;
    endfunction

    function automatic logic [2:0] exp_state();
        case (m_phase)
            MIdle:   return 3'd0;
            MCap:    return (m_trig < 0) ? 3'd1 : 3'd2;
            MFrozen: return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expected sample on every handshake.
    always @(negedge CLK) begin
        if (RST) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", DOUT_VALID, 1);
                check("stall_data", DOUT, prev_dout);
            end
            if (DOUT_VALID && DOUT_READY) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", DOUT_VALID, 0);
                end else begin
                    popped++;
                    check("readout", DOUT, sb.pop_front());
                end
            end
            stall_prev = DOUT_VALID && !DOUT_READY;
            prev_dout  = DOUT;
        end
    end

    // One clock of stimulus; the model is advanced with the same inputs.
    task automatic cycle(input bit v, input bit t, input bit a, input bit rs);
        DIN = make_din(cnt);
        DIN_VALID = v;
        TRIG = t;
        ARM = a;
        RD_START = rs;
        if (rs && m_phase == MFrozen) begin
            int n;
            n = (hist.size() < DEPTH) ? hist.size() : DEPTH;
            for (int i = hist.size() - n; i < hist.size(); i++) sb.push_back(hist[i]);
            m_phase = (n == 0) ? MIdle : MRead;
        end else if (a && (m_phase == MIdle || m_phase == MFrozen)) begin
            hist.delete();
            m_post  = int'(POST_LEN);
            m_trig  = -1;
            m_phase = MCap;
        end else if (m_phase == MCap) begin
            if (t && m_trig < 0) begin
                m_trig     = hist.size();
                m_trig_adr = m_trig % DEPTH;
            end
            if (v) hist.push_back(DIN);
            if (m_trig >= 0 && hist.size() == m_trig + 1 + m_post) m_phase = MFrozen;
        end
        if (v) cnt++;
        @(posedge CLK);
        #1;
        DIN_VALID = 1'b0;
        TRIG = 1'b0;
        ARM = 1'b0;
        RD_START = 1'b0;
        check("state", STATE, exp_state());
        check("trig_adr", TRIG_ADR, m_trig_adr);
        check("wrapped", WRAPPED, hist.size() >= DEPTH);
        if (m_phase != MRead) check("dout_valid_off", DOUT_VALID, 0);
    endtask

    task automatic capture(input int post, input int trig_at, input int vrate,
                           input bit novalid, input bit extra);
        bit v;
        bit t;
        POST_LEN = AW'(post);
        cnt = '0;
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 400 && m_phase == MCap; i++) begin
            t = (m_trig < 0 && cnt >= 12'(trig_at)) ||
                (extra && m_trig >= 0 && $urandom_range(0, 2) == 0);
            v = ($urandom_range(1, 100) <= vrate);
            if (m_trig < 0 && t && novalid) v = 1'b0;
            cycle(v, t, 0, 0);
        end
        check("frozen", STATE, 3);
    endtask

    // Readout; rst_at > 0 asserts RST on the edge carrying that transfer number.
    task automatic do_read(input bit rand_ready, input int rst_at);
        popped = 0;
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 300 && STATE != 3'd0; i++) begin
            DOUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rand_ready && sb.size() >= 2) begin
                ARM      = 1'($urandom_range(0, 1));
                TRIG     = 1'($urandom_range(0, 1));
                RD_START = 1'($urandom_range(0, 1));
            end
            if (rst_at > 0 && popped == rst_at - 1 && DOUT_VALID) RST = 1'b1;
            @(posedge CLK);
            #1;
            ARM = 1'b0;
            TRIG = 1'b0;
            RD_START = 1'b0;
            if (RST) begin
                RST = 1'b0;
                check("rst_state", STATE, 0);
                check("rst_dout_valid", DOUT_VALID, 0);
                check("rst_wrapped", WRAPPED, 0);
                check("rst_trig_adr", TRIG_ADR, 0);
                check("rst_dout", DOUT, 0);
                check("rst_transfers", popped, rst_at - 1);
                hist.delete();
                sb.delete();
                m_trig = -1;
                m_trig_adr = 0;
                m_phase = MIdle;
                return;
            end
        end
        check("read_end_state", STATE, 0);
        check("read_end_valid", DOUT_VALID, 0);
        check("sb_drained", sb.size(), 0);
        m_phase = MIdle;
        DOUT_READY = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", STATE, 0);
        check("reset_dout_valid", DOUT_VALID, 0);
        check("reset_trig_adr", TRIG_ADR, 0);
        check("reset_wrapped", WRAPPED, 0);
        check("reset_dout", DOUT, 0);
        RST = 1'b0;

        // TRIG, RD_START and DIN_VALID in IDLE are ignored.
        repeat (3) cycle(1, 1, 0, 1);

        // Wrapped capture: trigger with sample 12, three post samples, 20 samples offered.
        capture(3, 12, 100, 0, 0);
        while (cnt < 12'd20) cycle(1, 0, 0, 0);
        check("c1_trig_adr", TRIG_ADR, 12);
        check("c1_wrapped", WRAPPED, 1);
        do_read(0, 0);

        // POST_LEN=0, trigger with sample 5: six samples read back.
        capture(0, 5, 100, 0, 0);
        check("c2_trig_adr", TRIG_ADR, 5);
        check("c2_wrapped", WRAPPED, 0);
        do_read(1, 0);

        // Trigger without a sample: trigger sample is the next write.
        capture(2, 3, 100, 1, 1);
        check("c3_trig_adr", TRIG_ADR, 3);
        do_read(1, 0);

        // Randomised captures with stalls, stray TRIG in POST and ARM/TRIG during READ.
        for (int n = 0; n < 8; n++) begin
            capture($urandom_range(0, 15), $urandom_range(0, 30), $urandom_range(40, 100),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) cycle(1, 1, 0, 0);
            do_read(1, 0);
        end

        // Reset on the 4th readout transfer, then a clean capture afterwards.
        capture(1, 10, 100, 0, 0);
        do_read(0, 4);
        capture(4, 2, 70, 0, 0);
        do_read(1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
